// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register bank that feeds the PWM block.
// Frame layout is {write flag, 7-bit address, 8-bit data}, MSB first.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    ARMING,
    IDLE,
    SHIFT,
    COMMIT
  } spi_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises one asynchronous pin into clk and emits registered rise/fall pulses.
// The level output is delayed to line up with the pulses, so a data pin sampled alongside stays coherent.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign level = prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 write-only target: shifts host frames in and commits them to five PWM control registers
// only when chip-select is released after exactly one well-formed write frame.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5,
  parameter int FRAME_BITS  = spi_reg_pkg::FRAME_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_in,
  input  logic       copi_in,
  input  logic       ncs_in,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic copi_level, copi_rise, copi_fall;
  logic ncs_level, ncs_rise, ncs_fall;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .async_in(sclk_in),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst(rst), .async_in(copi_in),
    .level(copi_level), .rise(copi_rise), .fall(copi_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst(rst), .async_in(ncs_in),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  logic unused_sync_outputs;
  assign unused_sync_outputs = &{1'b0, sclk_level, sclk_fall, copi_rise, copi_fall};

  spi_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0]  shift_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [6:0]             frame_addr;
  logic [7:0]             frame_data;
  logic                   commit_ok;

  assign frame_addr = shift_q[FRAME_BITS-2:8];
  assign frame_data = shift_q[7:0];
  assign commit_ok  = (bit_cnt_q == CNT_FULL) && shift_q[FRAME_BITS-1]
                      && (int'(frame_addr) < NUM_REGS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARMING;
    end else begin
      state_q <= state_d;
    end
  end

  // ARMING holds off until chip-select is seen high so a reset released mid-frame cannot capture a fragment.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMING: if (ncs_level) state_d = IDLE;
      IDLE:   if (ncs_fall)  state_d = SHIFT;
      SHIFT:  if (ncs_rise)  state_d = COMMIT;
      COMMIT: state_d = IDLE;
      default: state_d = ARMING;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      wr_strobe       <= 1'b0;
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ncs_fall) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
          end
        end
        SHIFT: begin
          // A chip-select release in the same cycle as a clock edge ends the frame; that edge is dropped.
          if (sclk_rise && !ncs_rise) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], copi_level};
            if (bit_cnt_q != CNT_MAX) bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        COMMIT: begin
          if (commit_ok) begin
            wr_strobe <= 1'b1;
            case (frame_addr)
              ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data;
              ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data;
              ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data;
              ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data;
              ADDR_DUTY:      pwm_duty_cycle  <= frame_data;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed frames from the test plan plus randomized host traffic,
// checked every cycle against a frame-level register model.
module tb_spi_reg_bank;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = SYNC_STAGES + 1;
  localparam int LAT         = SYNC_STAGES + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk_in, copi_in, ncs_in;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_strobe;

  always #5 clk = ~clk;

  spi_reg_bank #(.SYNC_STAGES(SYNC_STAGES), .NUM_REGS(5), .FRAME_BITS(16)) dut (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .copi_in(copi_in), .ncs_in(ncs_in),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe)
  );

  typedef struct {
    int         edge_idx;
    int         addr;
    logic [7:0] data;
  } pend_t;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_strobes = 0;
  logic [7:0] model_regs [5];
  pend_t      pend_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Model: a committed write lands LAT edges after the first edge that samples chip-select high.
  always @(negedge clk) begin : compare
    logic exp_strobe;
    exp_strobe = 1'b0;
    if (rst) begin
      for (int i = 0; i < 5; i++) model_regs[i] = 8'h00;
      pend_q.delete();
    end else begin
      while (pend_q.size() > 0 && pend_q[0].edge_idx <= cyc) begin
        model_regs[pend_q[0].addr] = pend_q[0].data;
        if (pend_q[0].edge_idx == cyc) exp_strobe = 1'b1;
        void'(pend_q.pop_front());
      end
    end
    check_output("en_reg_out_7_0",  en_reg_out_7_0,  model_regs[0]);
    check_output("en_reg_out_15_8", en_reg_out_15_8, model_regs[1]);
    check_output("en_reg_pwm_7_0",  en_reg_pwm_7_0,  model_regs[2]);
    check_output("en_reg_pwm_15_8", en_reg_pwm_15_8, model_regs[3]);
    check_output("pwm_duty_cycle",  pwm_duty_cycle,  model_regs[4]);
    check_output("wr_strobe",       wr_strobe,       exp_strobe);
    if (wr_strobe) n_strobes++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bit(input logic b);
    copi_in = b;
    sclk_in = 1'b0;
    wait_clks(HALF + int'($urandom_range(0, 1)));
    sclk_in = 1'b1;
    wait_clks(HALF + int'($urandom_range(0, 1)));
    sclk_in = 1'b0;
  endtask

  task automatic open_frame();
    ncs_in  = 1'b0;
    sclk_in = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic release_cs(input logic [31:0] bits, input int nbits);
    ncs_in = 1'b1;
    if (nbits == 16 && bits[15] && bits[14:8] < 7'd5)
      pend_q.push_back('{edge_idx: cyc + 1 + LAT, addr: int'(bits[14:8]), data: bits[7:0]});
  endtask

  task automatic apply_stimulus(input logic [31:0] bits, input int nbits);
    open_frame();
    for (int i = nbits - 1; i >= 0; i--) shift_bit(bits[i]);
    wait_clks(HALF);
    release_cs(bits, nbits);
    wait_clks(HALF);
  endtask

  task automatic check_regs(input logic [7:0] r0, r1, r2, r3, r4);
    check_output("lit_en_reg_out_7_0",  en_reg_out_7_0,  r0);
    check_output("lit_en_reg_out_15_8", en_reg_out_15_8, r1);
    check_output("lit_en_reg_pwm_7_0",  en_reg_pwm_7_0,  r2);
    check_output("lit_en_reg_pwm_15_8", en_reg_pwm_15_8, r3);
    check_output("lit_pwm_duty_cycle",  pwm_duty_cycle,  r4);
  endtask

  initial begin : watchdog
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int         s0;
    int         e0;
    int         lat;
    logic [31:0] v;
    int         nb;
    rst = 1'b1; sclk_in = 1'b0; copi_in = 1'b0; ncs_in = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(20);
    $display("[TB] reset and idle");
    check_regs(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check_output("strobes_after_reset", n_strobes, 0);

    $display("[TB] basic writes");
    s0 = n_strobes;
    apply_stimulus(32'h80F0, 16);
    apply_stimulus(32'h84C0, 16);
    wait_clks(LAT + 2);
    check_regs(8'hF0, 8'h00, 8'h00, 8'h00, 8'hC0);
    check_output("strobes_basic", n_strobes - s0, 2);

    $display("[TB] discarded frames");
    s0 = n_strobes;
    apply_stimulus(32'h8155 >> 1, 15);
    apply_stimulus({15'd0, 16'h8155, 1'b1}, 17);
    apply_stimulus(32'h01AA, 16);
    apply_stimulus(32'h85FF, 16);
    wait_clks(LAT + 2);
    check_regs(8'hF0, 8'h00, 8'h00, 8'h00, 8'hC0);
    check_output("strobes_discarded", n_strobes - s0, 0);

    $display("[TB] sclk and ncs rising together");
    s0 = n_strobes;
    v = 32'h8277;
    open_frame();
    for (int i = 15; i >= 0; i--) shift_bit(v[i]);
    wait_clks(HALF);
    copi_in = 1'b1;
    sclk_in = 1'b1;
    release_cs(v, 16);
    wait_clks(HALF);
    sclk_in = 1'b0;
    wait_clks(LAT + 2);
    check_output("lit_same_cycle_pwm_lo", en_reg_pwm_7_0, 8'h77);
    check_output("strobes_same_cycle", n_strobes - s0, 1);

    $display("[TB] reset mid-frame");
    s0 = n_strobes;
    v = 32'h8144;
    open_frame();
    for (int i = 15; i >= 8; i--) shift_bit(v[i]);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    for (int i = 7; i >= 0; i--) shift_bit(v[i]);
    wait_clks(HALF);
    ncs_in = 1'b1;
    wait_clks(HALF);
    wait_clks(LAT + 2);
    check_regs(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check_output("strobes_reset_frame", n_strobes - s0, 0);
    apply_stimulus(32'h8233, 16);
    wait_clks(LAT + 2);
    check_output("lit_after_reset_pwm_lo", en_reg_pwm_7_0, 8'h33);

    $display("[TB] back-to-back writes");
    s0 = n_strobes;
    apply_stimulus(32'h8311, 16);
    apply_stimulus(32'h8322, 16);
    wait_clks(LAT + 2);
    check_output("lit_b2b_pwm_hi", en_reg_pwm_15_8, 8'h22);
    check_output("strobes_b2b", n_strobes - s0, 2);

    $display("[TB] latency");
    v = 32'h80A5;
    open_frame();
    for (int i = 15; i >= 0; i--) shift_bit(v[i]);
    wait_clks(HALF);
    e0 = cyc + 1;
    release_cs(v, 16);
    lat = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (en_reg_out_7_0 == 8'hA5) lat = cyc - e0;
    end
    check_output("latency_cycles", lat, 4);
    wait_clks(HALF);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int t = 0; t < 3; t++) begin
          sclk_in = 1'b1; wait_clks(HALF);
          sclk_in = 1'b0; wait_clks(HALF);
        end
      end
      v = {16'd0, ($urandom_range(0, 3) != 0), 7'($urandom_range(0, 7)), 8'($urandom)};
      case ($urandom_range(0, 5))
        0: begin v = v >> 1; nb = 15; end
        1: begin v = {v[30:0], 1'($urandom)}; nb = 17; end
        default: nb = 16;
      endcase
      apply_stimulus(v, nb);
      wait_clks(int'($urandom_range(0, 4)));
    end
    wait_clks(LAT + 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Upstream stage of pwm_peripheral: an SPI mode-0, write-only target that turns host frames on ui_in into the five 8-bit control registers driving the PWM block.
- Three raw pins are synchronised into clk and shifted into 16-bit frames.
- A frame is committed to the register file only on a clean chip-select release.
- Sits in the top level between ui_in[2:0] and the pwm_peripheral register inputs.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser (legal: 2 or 3)
- NUM_REGS, 5, number of implemented registers at addresses 0x00..NUM_REGS-1
- FRAME_BITS, 16, bits per valid frame (fixed encoding below; not for override)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- sclk_in  input  1  SPI clock from host, asynchronous to clk
- copi_in  input  1  SPI data from host, asynchronous
- ncs_in  input  1  SPI chip select, active-low, asynchronous
- en_reg_out_7_0  output  8  register 0x00
- en_reg_out_15_8  output  8  register 0x01
- en_reg_pwm_7_0  output  8  register 0x02
- en_reg_pwm_15_8  output  8  register 0x03
- pwm_duty_cycle  output  8  register 0x04
- wr_strobe  output  1  one-cycle pulse when a register is written

Behaviour:
- Reset (asynchronous assert, synchronous-safe release):
  - all registers, synchronisers, shift register and bit counter go to 0
  - wr_strobe=0; FSM goes to ARMING
- Sync and edge detect:
  - each input passes through a SYNC_STAGES flip-flop chain
  - sclk rise = synced sclk high AND previous synced sample low; ncs fall and ncs rise are detected the same way
- Frame format, MSB first:
  - bit15 = R/W (1 = write)
  - bits14:8 = address
  - bits7:0 = data
- FSM states:
  - ARMING: wait until synced ncs is high, then go to IDLE. This prevents a mid-frame reset release from capturing a partial frame.
  - IDLE: on ncs fall, clear the bit counter and shift register, then go to SHIFT.
  - SHIFT: on each sclk rise, shift in synced copi; the bit counter increments and saturates at FRAME_BITS+1. On ncs rise, go to COMMIT.
  - COMMIT: one cycle. Write data to register[address] only if count==FRAME_BITS AND R/W=1 AND address<NUM_REGS; pulse wr_strobe in that same cycle. Otherwise discard silently. Then go to IDLE.
- Boundary rules:
  - Short frame (<16 bits) or long frame (>16 bits): discarded, no register change.
  - Read frame (R/W=0): discarded; this block has no read-back.
  - Address >= NUM_REGS: discarded, no strobe.
  - sclk rise and ncs rise detected in the same clk cycle: the ncs rise wins and that sclk edge is not shifted.
  - sclk edges while in IDLE or ARMING are ignored.
  - Reset asserted mid-frame: frame lost; a new ncs high-then-low is required.
- Latency:
  - a register output updates on the clk edge ending COMMIT
  - that edge is SYNC_STAGES+2 clk cycles after the first clk edge that samples ncs_in high
- Host timing requirement: each sclk high and low phase, and the ncs high time between frames, must be >= SYNC_STAGES+1 clk periods.
- Registers hold their values indefinitely between writes. Outputs are driven directly from flops.

Decomposition:
- Shared package spi_reg_pkg:
  - address constants ADDR_EN_OUT_LO=0x00, ADDR_EN_OUT_HI=0x01, ADDR_EN_PWM_LO=0x02, ADDR_EN_PWM_HI=0x03, ADDR_DUTY=0x04
  - FRAME_BITS
  - FSM state enum {ARMING, IDLE, SHIFT, COMMIT}
- One natural sub-module: sync_edge_detect, which synchronises one input and emits rise/fall pulses. It is instantiated three times.
- The register file stays inline in spi_reg_bank.

Test Plan:
- Reset, then idle pins with ncs=1 -> all five registers 0x00, wr_strobe never asserts.
- Write frame 0x80F0 (addr 0x00, data 0xF0) then 0x84C0 (addr 0x04, data 0xC0) -> en_reg_out_7_0=0xF0 and pwm_duty_cycle=0xC0, exactly one wr_strobe per frame, other registers unchanged.
- Frames of 15 bits and 17 bits carrying 0x8155, read frame 0x01AA, and address-0x05 frame 0x85FF -> no register change, no wr_strobe.
- rst pulsed after 8 bits of a frame with ncs held low, remaining bits then clocked -> nothing written. A following full frame 0x8233 -> en_reg_pwm_7_0=0x33.
- Back-to-back writes 0x8311 then 0x8322 with minimum ncs gap (SYNC_STAGES+1 clk) -> en_reg_pwm_15_8 ends at 0x22, two wr_strobe pulses.
- Latency check on any valid write -> output changes exactly SYNC_STAGES+2 clk cycles after ncs_in is first sampled high.
